// File: rtl/wrb_queue_if.sv
// rtl/wrb_queue_if.sv - push, drain, lookup and status signals of the write-back queue
interface wrb_queue_if #(
    parameter int WIDTH_ADDR = 8,
    parameter int WIDTH_ROW  = 512,
    parameter int DEPTH      = 4,
    parameter int DEPTH_PTR  = $clog2(DEPTH)
);
    logic                  wrb_val;
    logic [WIDTH_ADDR-1:0] wrb_addr;
    logic [WIDTH_ROW-1:0]  wrb_data;
    logic                  mem_val;
    logic [WIDTH_ADDR-1:0] mem_addr;
    logic [WIDTH_ROW-1:0]  mem_data;
    logic                  mem_rdy;
    logic                  lk_val;
    logic [WIDTH_ADDR-1:0] lk_addr;
    logic                  lk_hit;
    logic [WIDTH_ROW-1:0]  lk_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_PTR:0]    count;
    logic                  ovf;

    modport slave (
        input  wrb_val, wrb_addr, wrb_data, mem_rdy, lk_val, lk_addr,
        output mem_val, mem_addr, mem_data, lk_hit, lk_data, full, empty, count, ovf
    );

    modport master (
        output wrb_val, wrb_addr, wrb_data, mem_rdy, lk_val, lk_addr,
        input  mem_val, mem_addr, mem_data, lk_hit, lk_data, full, empty, count, ovf
    );
endinterface

// File: rtl/wrb_queue.sv
// rtl/wrb_queue.sv - in-order write-back queue with overflow flag and forwarding lookup
module wrb_queue #(
    parameter int WIDTH_ADDR = 8,
    parameter int WIDTH_ROW  = 512,
    parameter int DEPTH      = 4,
    parameter int DEPTH_PTR  = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    wrb_queue_if.slave bus
);
    logic [DEPTH-1:0]      valid_q;
    logic [WIDTH_ADDR-1:0] addr_q [DEPTH];
    logic [WIDTH_ROW-1:0]  data_q [DEPTH];
    logic [DEPTH_PTR-1:0]  wp_q;
    logic [DEPTH_PTR-1:0]  rp_q;
    logic [DEPTH_PTR:0]    cnt_q;
    logic                  ovf_q;

    logic full;
    logic empty;
    logic pop;
    logic push;

    assign full  = (cnt_q == (DEPTH_PTR+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = ~empty & bus.mem_rdy;
    assign push  = bus.wrb_val & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // when full, wp == rp: the push's set must win over the pop's clear
            if (pop) begin
                valid_q[rp_q] <= 1'b0;
                rp_q          <= rp_q + 1'b1;
            end
            if (push) begin
                valid_q[wp_q] <= 1'b1;
                wp_q          <= wp_q + 1'b1;
            end
            if (push && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !push)
                cnt_q <= cnt_q - 1'b1;
            if (bus.wrb_val && !push)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wp_q] <= bus.wrb_addr;
            data_q[wp_q] <= bus.wrb_data;
        end
    end

    // walk from the head toward wp so the youngest match is the one kept
    logic                 hit;
    logic [WIDTH_ROW-1:0] hit_data;
    logic [DEPTH_PTR-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = rp_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp_q + DEPTH_PTR'(i);
            if (valid_q[idx] && addr_q[idx] == bus.lk_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign bus.mem_val  = ~empty;
    assign bus.mem_addr = addr_q[rp_q];
    assign bus.mem_data = data_q[rp_q];
    assign bus.lk_hit   = bus.lk_val & hit;
    assign bus.lk_data  = hit_data;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = cnt_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: doc/wrb_queue.md
Name: wrb_queue

Overview:
- Write-back queue directly downstream of the line buffer.
- Captures each evicted row presented on the buffer's wrb_val/wrb_addr/wrb_data outputs and drains rows in order to the memory side over a valid/ready handshake.
- The buffer has no back-pressure, so the queue absorbs bursts of releases and flags overflow.
- Provides an address lookup port so the read path can detect rows still in flight to memory and forward them.

Parameters:
- WIDTH_ADDR, 8, row address width.
- WIDTH_ROW, 512, row data width (8 * 64).
- DEPTH, 4, number of queue entries; must be a power of two, >= 2.
- DEPTH_PTR, clogb2(DEPTH), pointer width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wrb_val  in  1  push strobe from buffer release path.
- wrb_addr  in  WIDTH_ADDR  address of pushed row.
- wrb_data  in  WIDTH_ROW  data of pushed row.
- mem_val  out  1  head entry valid toward memory.
- mem_addr  out  WIDTH_ADDR  head entry address.
- mem_data  out  WIDTH_ROW  head entry data.
- mem_rdy  in  1  memory accepts head this cycle.
- lk_val  in  1  lookup request.
- lk_addr  in  WIDTH_ADDR  lookup address.
- lk_hit  out  1  lookup address is pending in queue.
- lk_data  out  WIDTH_ROW  data of youngest matching entry.
- full  out  1  all DEPTH entries occupied.
- empty  out  1  no entries occupied.
- count  out  DEPTH_PTR+1  occupied entry count, 0..DEPTH.
- ovf  out  1  sticky overflow error.

Behaviour:
- Reset values (rst low, asynchronous):
  - Write/read pointers 0; all entry valid bits 0.
  - count=0, empty=1, full=0, mem_val=0, ovf=0, lk_hit=0.
  - Entry storage is not reset; mem_addr/mem_data/lk_data are don't-care while their qualifier is 0.
- Storage: circular array of DEPTH entries {valid, addr, data}; write pointer wp, read pointer rp. Both wrap modulo DEPTH (DEPTH-1 -> 0).
- pop = mem_val & mem_rdy.
  - On pop: entry[rp].valid cleared, rp advances.
- push = wrb_val & (~full | pop).
  - On push: entry[wp] <= {1, wrb_addr, wrb_data}, wp advances.
  - A push into a full queue is legal when pop occurs in the same cycle; count stays DEPTH.
- Drop: wrb_val & full & ~pop drops the incoming row, leaves contents unchanged, and sets ovf=1. ovf holds until reset.
- count update: count_next = count + push - pop.
  - full = (count==DEPTH); empty = (count==0).
  - All three are registered-state derived, with no combinational path from inputs.
- Memory side:
  - mem_val = ~empty; mem_addr/mem_data = entry[rp] fields, read directly from storage.
  - Zero-cycle latency from head availability to mem_val.
  - A row pushed into an empty queue appears on mem_val the cycle after the push edge.
  - While mem_val & ~mem_rdy, mem_addr/mem_data are held stable (head is not overwritten, since wp != rp when not full).
- Ordering: strict FIFO; entries with the same address are drained in push order, and no coalescing is performed.
- Lookup (combinational):
  - lk_hit = lk_val & (any valid entry with addr==lk_addr).
  - lk_data = data of the youngest valid matching entry, i.e. the one closest behind wp.
  - The entry being popped in the current cycle still counts as a hit.
  - A row being pushed in the current cycle is not visible until the next cycle.
  - lk_val=0 forces lk_hit=0.
- Reset mid-operation: all pending entries are discarded immediately; mem_val falls asynchronously with rst.

Test Plan:
- Reset, then push addr 0x13/data 0xaa with mem_rdy=0 -> next cycle mem_val=1, mem_addr=0x13, mem_data=0xaa, count=1, empty=0; outputs held over 3 stalled cycles; raise mem_rdy one cycle -> count=0, mem_val=0.
- Push 0x01/0xbb, 0x02/0xcc, 0x03/0xdd back-to-back, then mem_rdy=1 -> memory receives 0x01, 0x02, 0x03 in that order on consecutive cycles; empty=1 afterwards.
- Push 4 rows (DEPTH=4) with mem_rdy=0 -> full=1, count=4; 5th push 0x55 -> dropped, ovf=1, head still first row; ovf stays 1 after queue drains.
- Full queue, wrb_val=1 with addr 0x66 and mem_rdy=1 same cycle -> head popped, 0x66 accepted, count stays 4, ovf=0; 0x66 drains last.
- Push 0x10/0x11 then 0x10/0x22 -> lk_addr=0x10 gives lk_hit=1, lk_data=0x22; lk_addr=0x20 gives lk_hit=0; same-cycle push of 0x30 with lk_addr=0x30 gives lk_hit=0, and lk_hit=1 next cycle.
- Run 10 pushes/pops to wrap pointers twice, then assert rst low with 2 entries pending -> count=0, mem_val=0 immediately; queue accepts pushes normally after release.
